// File: rtl/fifo_port_scheduler.sv
// fifo_port_scheduler
// Shares one FIFO between NUM_REQ round-robin producers and a single consumer.
// Each cycle at most one FIFO operation is issued (write or read, never both),
// because the FIFO occupancy counter cannot handle simultaneous operations.
// When both are wanted they alternate, so neither side can starve the other.
//
// Handshakes: every valid/ready pair in this block transfers an item on a cycle
// where valid && ready are both high. A producer keeps valid and data steady
// until it sees ready, and may drop valid beforehand to withdraw its item. The
// consumer side (out_valid/out_data) holds its item steady while out_ready is
// low.
module fifo_port_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ITEM_SIZE_BITS = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*ITEM_SIZE_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              fifo_write,
  output logic [ITEM_SIZE_BITS-1:0]         fifo_data_in,
  input  logic                              fifo_full,
  output logic                              fifo_read,
  input  logic [ITEM_SIZE_BITS-1:0]         fifo_data_out,
  input  logic                              fifo_empty,
  output logic                              out_valid,
  output logic [ITEM_SIZE_BITS-1:0]         out_data,
  input  logic                              out_ready,
  output logic                              rd_state_dbg
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_VALID = 1'b1
  } rd_state_t;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_ptr_nxt;
  logic [PTR_W-1:0] grant_idx;
  logic             last_op;      // 0 = last op was a write, 1 = a read
  rd_state_t        rd_state;
  rd_state_t        rd_state_nxt;
  logic             write_pending;
  logic             read_pending;
  logic             do_write;
  logic             do_read;

  // Producer index at a given offset from base, wrapping at NUM_REQ.
  function automatic logic [PTR_W-1:0] cand_idx(input logic [PTR_W-1:0] base,
                                                input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // Round-robin search: walk offsets from far to near so the nearest valid
  // producer to rr_ptr overwrites any further one.
  always_comb begin
    grant_idx = rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[cand_idx(rr_ptr, i)]) grant_idx = cand_idx(rr_ptr, i);
    end
  end

  // Slot choice. Gated by rst_n so nothing is issued while reset is held.
  assign write_pending = (|req_valid) && !fifo_full;
  assign read_pending  = !fifo_empty && ((rd_state == R_IDLE) || out_ready);
  assign do_write      = rst_n && write_pending && (!read_pending || last_op);
  assign do_read       = rst_n && read_pending && !do_write;

  assign rr_ptr_nxt = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                         : grant_idx + 1'b1;

  // The FIFO registers data_out, so the item is valid while in R_VALID.
  assign fifo_data_in = req_data[int'(grant_idx)*ITEM_SIZE_BITS +: ITEM_SIZE_BITS];
  assign out_data     = fifo_data_out;
  assign out_valid    = (rd_state == R_VALID);
  assign rd_state_dbg = rd_state;

  // FIFO command outputs and read-stream next state.
  always_comb begin
    req_ready    = '0;
    fifo_write   = 1'b0;
    fifo_read    = 1'b0;
    rd_state_nxt = rd_state;
    if (do_write) begin
      fifo_write           = 1'b1;
      req_ready[grant_idx] = 1'b1;
    end
    if (do_read) fifo_read = 1'b1;
    case (rd_state)
      R_IDLE:  if (do_read) rd_state_nxt = R_VALID;
      R_VALID: if (out_ready) rd_state_nxt = do_read ? R_VALID : R_IDLE;
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // Read-stream state register; a pending unaccepted item is dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_state <= R_IDLE;
    else        rd_state <= rd_state_nxt;
  end

  // Arbitration state: pointer advances past a granted producer, and last_op
  // remembers the issued operation so a tie goes to the other side next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      last_op <= 1'b1;
    end else begin
      if (do_write) begin
        rr_ptr  <= rr_ptr_nxt;
        last_op <= 1'b0;
      end else if (do_read) begin
        last_op <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_port_scheduler.sv
// tb_fifo_port_scheduler
// Drives fifo_port_scheduler against either forced FIFO flags or a small
// behavioural FIFO (registered data_out and flags), checking grants, slot
// alternation, stream timing and item order.
module tb_fifo_port_scheduler;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_write;
  logic [W-1:0]   fifo_data_in;
  logic           fifo_full;
  logic           fifo_read;
  logic [W-1:0]   fifo_data_out;
  logic           fifo_empty;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic           rd_state_dbg;

  logic use_model;
  logic force_empty;
  logic force_full;

  fifo_port_scheduler #(.NUM_REQ(N), .ITEM_SIZE_BITS(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_write   (fifo_write),
    .fifo_data_in (fifo_data_in),
    .fifo_full    (fifo_full),
    .fifo_read    (fifo_read),
    .fifo_data_out(fifo_data_out),
    .fifo_empty   (fifo_empty),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .rd_state_dbg (rd_state_dbg)
  );

  // ---------------- behavioural FIFO ----------------
  logic [W-1:0] mem [DEPTH];
  int           cnt, wp, rp;
  logic [W-1:0] m_dout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 0; wp <= 0; rp <= 0; m_dout <= '0;
    end else if (use_model) begin
      if (fifo_write && cnt < DEPTH) begin
        mem[wp] <= fifo_data_in;
        wp      <= (wp + 1) % DEPTH;
      end
      if (fifo_read && cnt > 0) begin
        m_dout <= mem[rp];
        rp     <= (rp + 1) % DEPTH;
      end
      cnt <= cnt + ((fifo_write && cnt < DEPTH) ? 1 : 0)
                 - ((fifo_read && cnt > 0) ? 1 : 0);
    end
  end

  assign fifo_empty    = use_model ? (cnt == 0)     : force_empty;
  assign fifo_full     = use_model ? (cnt == DEPTH) : force_full;
  assign fifo_data_out = m_dout;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [W-1:0] act,
                          input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int k, input logic [W-1:0] v);
    req_data[k*W +: W] = v;
  endtask

  // Items in flight are discarded by reset.
  always @(negedge rst_n) exp_q.delete();

  // ---------------- scoreboard / per-cycle monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      logic [W-1:0] d;
      d = '0;
      check_eq("excl", {31'd0, fifo_write && fifo_read}, '0);
      check_eq("onehot", {31'd0, $onehot0(req_ready)}, 32'd1);
      check_eq("rdy_vs_wr", {31'd0, |req_ready}, {31'd0, fifo_write});
      if (use_model && fifo_write) begin
        for (int k = 0; k < N; k++) if (req_ready[k]) d = req_data[k*W +: W];
        check_eq("din", fifo_data_in, d);
        exp_q.push_back(d);
      end
      if (use_model && out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("sb_empty", 32'd1, 32'd0);
        else check_eq("sb_data", out_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [N-1:0] rr_tbl [8];
  logic         ord_w  [6];
  logic         ord_r  [6];
  logic         ord_ov [6];
  logic [W-1:0] d0;
  logic         acc;
  bit           found;

  initial begin
    rr_tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010,
               4'b1000, 4'b0010};
    ord_w  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    ord_r  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    ord_ov = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; use_model = 1'b0; force_empty = 1'b0; force_full = 1'b0;
    out_ready = 1'b0; req_valid = 4'hF;
    for (int k = 0; k < N; k++) set_slot(k, 32'hC0DE_0000 + W'(k));

    // Reset held with all producers valid and FIFO non-empty.
    tick(); tick();
    @(negedge clk);
    check_eq("rst_ready", {28'd0, req_ready}, '0);
    check_eq("rst_write", {31'd0, fifo_write}, '0);
    check_eq("rst_read",  {31'd0, fifo_read}, '0);
    check_eq("rst_ovalid", {31'd0, out_valid}, '0);
    check_eq("rst_state", {31'd0, rd_state_dbg}, '0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("tie_ready", {28'd0, req_ready}, 32'h1);
    check_eq("tie_write", {31'd0, fifo_write}, 32'd1);
    check_eq("tie_read",  {31'd0, fifo_read}, 32'd0);

    // Round robin with no reads possible.
    tick(); rst_n = 1'b0; force_empty = 1'b1;
    tick(); rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 6) req_valid = 4'b1010;
      @(negedge clk);
      check_eq($sformatf("rr%0d", c), {28'd0, req_ready}, {28'd0, rr_tbl[c]});
      tick();
    end

    // Ordering through the behavioural FIFO, producer 2 only.
    rst_n = 1'b0; use_model = 1'b1; req_valid = '0; out_ready = 1'b1;
    tick(); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      req_valid = (c < 3) ? 4'b0100 : 4'b0000;
      set_slot(2, (c == 0) ? 32'hA5A5_0001 : 32'hA5A5_0002);
      @(negedge clk);
      check_eq($sformatf("ord_w%0d", c),  {31'd0, fifo_write}, {31'd0, ord_w[c]});
      check_eq($sformatf("ord_r%0d", c),  {31'd0, fifo_read},  {31'd0, ord_r[c]});
      check_eq($sformatf("ord_ov%0d", c), {31'd0, out_valid},  {31'd0, ord_ov[c]});
      if (c == 2) check_eq("ord_d1", out_data, 32'hA5A5_0001);
      if (c == 4) check_eq("ord_d2", out_data, 32'hA5A5_0002);
      tick();
    end

    // Backpressure, fill to full, then contention with out_ready high.
    rst_n = 1'b0; req_valid = 4'b0001; out_ready = 1'b0;
    d0 = 32'h1000_0000;
    set_slot(0, d0);
    tick(); rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 12) out_ready = 1'b1;
      @(negedge clk);
      acc = req_ready[0];
      if (c < 12) begin
        check_eq($sformatf("bp_w%0d", c), {31'd0, fifo_write},
                 {31'd0, (c == 0) || (c >= 2 && c <= 9)});
        check_eq($sformatf("bp_r%0d", c), {31'd0, fifo_read}, {31'd0, c == 1});
        if (c >= 2) begin
          check_eq($sformatf("bp_ov%0d", c), {31'd0, out_valid}, 32'd1);
          check_eq($sformatf("bp_hold%0d", c), out_data, d0);
          check_eq($sformatf("bp_st%0d", c), {31'd0, rd_state_dbg}, 32'd1);
        end
        if (c >= 10) check_eq($sformatf("full_stall%0d", c), {28'd0, req_ready}, '0);
      end else begin
        check_eq($sformatf("alt_w%0d", c), {31'd0, fifo_write}, {31'd0, c[0]});
        check_eq($sformatf("alt_r%0d", c), {31'd0, fifo_read},  {31'd0, !c[0]});
      end
      tick();
      if (acc) set_slot(0, req_data[0 +: W] + 32'd1);
    end

    // Asynchronous reset while an item is presented.
    out_ready = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
      else tick();
    end
    check_eq("ar_ov_before", {31'd0, found}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("ar_ov", {31'd0, out_valid}, '0);
    check_eq("ar_read", {31'd0, fifo_read}, '0);
    check_eq("ar_ready", {28'd0, req_ready}, '0);
    #1 rst_n = 1'b1; req_valid = 4'hF;
    #1;
    check_eq("ar_ptr", {28'd0, req_ready}, 32'h1);
    req_valid = '0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
